// File: rtl/stopwatch_btn_cond_if.sv
// rtl/stopwatch_btn_cond_if.sv - button/command bundle between the panel and the stopwatch counter
//
// Signals:
//   btn_start, btn_pause, btn_reset       raw asynchronous push-buttons, active-high
//   start_pulse, pause_pulse, reset_pulse one-cycle command pulses toward the counter
//   start_db, pause_db, reset_db          debounced button levels
// Modports:
//   master  drives the raw buttons and observes the conditioned outputs
//   slave   the conditioner: consumes the raw buttons, drives the outputs

interface stopwatch_btn_cond_if;
    logic btn_start;
    logic btn_pause;
    logic btn_reset;
    logic start_pulse;
    logic pause_pulse;
    logic reset_pulse;
    logic start_db;
    logic pause_db;
    logic reset_db;

    modport master (
        output btn_start, btn_pause, btn_reset,
        input  start_pulse, pause_pulse, reset_pulse,
        input  start_db, pause_db, reset_db
    );

    modport slave (
        input  btn_start, btn_pause, btn_reset,
        output start_pulse, pause_pulse, reset_pulse,
        output start_db, pause_db, reset_db
    );
endinterface

// File: rtl/stopwatch_btn_cond.sv
// rtl/stopwatch_btn_cond.sv - synchronise, debounce and pulse-encode the three stopwatch buttons
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a press or a release (>= 2)
//   HOLD_CYCLES      HELD cycles of the pause button before hold-to-clear fires (> DEBOUNCE_CYCLES)
//   CNT_W            counter width, 2**CNT_W > max(DEBOUNCE_CYCLES, HOLD_CYCLES)
// Ports:
//   clk     system clock
//   reset   synchronous, active-high
//   io_bus  slave side of stopwatch_btn_cond_if (raw buttons in, pulses and debounced levels out)
// Build option:
//   STOPWATCH_HOLD_CLR_EN  when defined, holding pause for HOLD_CYCLES also issues reset_pulse

module stopwatch_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 100000000,
    parameter int CNT_W           = 27
) (
    input  logic                  clk,
    input  logic                  reset,
    stopwatch_btn_cond_if.slave   io_bus
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
        $error("stopwatch_btn_cond: DEBOUNCE_CYCLES/HOLD_CYCLES out of range");
    end

    // Bit order everywhere: [0] start, [1] pause, [2] reset.
    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_fire;     // press accepted on this edge (PRESS_WAIT -> HELD)
    logic [2:0] w_db;
    logic       w_hold_fire;
    logic       w_reset_cmd;

    logic       r_start_pulse;
    logic       r_pause_pulse;
    logic       r_reset_pulse;

    assign w_raw = {io_bus.btn_reset, io_bus.btn_pause, io_bus.btn_start};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef STOPWATCH_HOLD_CLR_EN
    logic w_pause_held;
`endif

    for (genvar i = 0; i < 3; i++) begin : g_btn
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_db;
        logic             w_s;

        assign w_s       = r_sync2[i];
        assign w_db[i]   = r_db;
        assign w_fire[i] = (r_state == ST_PRESS_WAIT) && w_s && (r_cnt == DB_LAST);

`ifdef STOPWATCH_HOLD_CLR_EN
        if (i == 1) begin : g_pause_held
            assign w_pause_held = (r_state == ST_HELD);
        end
`endif

        // cnt is cleared on every state change and only counts up to DB_LAST,
        // so it can never wrap.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_db    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_s) begin
                            r_state <= ST_PRESS_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!w_s) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == DB_LAST) begin
                            r_state <= ST_HELD;
                            r_cnt   <= '0;
                            r_db    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (!w_s) begin
                            r_state <= ST_RELEASE_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (w_s) begin
                            r_state <= ST_HELD;
                            r_cnt   <= '0;
                        end else if (r_cnt == DB_LAST) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_db    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_db    <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef STOPWATCH_HOLD_CLR_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_hold_done;

    // The hold counter restarts only when a new pause press is accepted, so a
    // short bounce in RELEASE_WAIT pauses the count instead of restarting it.
    // r_hold_done stops counting after the single hold-to-clear of a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt  <= '0;
            r_hold_done <= 1'b0;
        end else if (w_fire[1]) begin
            r_hold_cnt  <= '0;
            r_hold_done <= 1'b0;
        end else if (w_pause_held && !r_hold_done) begin
            if (r_hold_cnt == HOLD_LAST) begin
                r_hold_done <= 1'b1;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign w_hold_fire = w_pause_held && !r_hold_done && (r_hold_cnt == HOLD_LAST);
`else
    assign w_hold_fire = 1'b0;
`endif

    assign w_reset_cmd = w_fire[2] | w_hold_fire;

    // A reset command masks start/pause in the same cycle; the masked press is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_pulse <= 1'b0;
            r_pause_pulse <= 1'b0;
            r_reset_pulse <= 1'b0;
        end else begin
            r_start_pulse <= w_fire[0] & ~w_reset_cmd;
            r_pause_pulse <= w_fire[1] & ~w_reset_cmd;
            r_reset_pulse <= w_reset_cmd;
        end
    end

    assign io_bus.start_pulse = r_start_pulse;
    assign io_bus.pause_pulse = r_pause_pulse;
    assign io_bus.reset_pulse = r_reset_pulse;
    assign io_bus.start_db    = w_db[0];
    assign io_bus.pause_db    = w_db[1];
    assign io_bus.reset_db    = w_db[2];

endmodule

// File: tb/tb_stopwatch_btn_cond.sv
// tb/tb_stopwatch_btn_cond.sv - scoreboard bench for stopwatch_btn_cond

module tb_stopwatch_btn_cond;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    stopwatch_btn_cond_if bus ();

    stopwatch_btn_cond #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .CNT_W           (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    typedef struct packed {
        logic [2:0] pulse;  // {reset, pause, start}
        logic [2:0] db;     // {reset, pause, start}
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model: raw inputs reach the debouncer two edges late; a
    // debounced level flips once DEB+1 consecutive samples disagree with it.
    logic [2:0] raw_q[$];
    logic [2:0] m_db;
    int         m_run[3];
    int         m_hold_n;
    bit         m_hold_done;

    task automatic model_edge(input logic rst, input logic [2:0] raw);
        logic [2:0] s;
        logic [2:0] fire;
        logic       hold_fire;
        logic       rst_ev;
        exp_t       e;
        if (rst) begin
            raw_q       = {3'b000, 3'b000};
            m_db        = '0;
            m_run       = '{0, 0, 0};
            m_hold_n    = 0;
            m_hold_done = 1'b0;
            exp_q.push_back('0);
            return;
        end
        s = raw_q.pop_front();
        raw_q.push_back(raw);
        hold_fire = 1'b0;
`ifdef STOPWATCH_HOLD_CLR_EN
        // counts edges spent in a settled held pause press
        if (m_db[1] && m_run[1] == 0 && !m_hold_done) begin
            m_hold_n++;
            if (m_hold_n == HOLD) begin
                hold_fire   = 1'b1;
                m_hold_done = 1'b1;
            end
        end
`endif
        fire = '0;
        for (int i = 0; i < 3; i++) begin
            if (s[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB + 1) begin
                    m_db[i]  = s[i];
                    m_run[i] = 0;
                    fire[i]  = s[i];
                    if (i == 1 && s[i]) begin
                        m_hold_n    = 0;
                        m_hold_done = 1'b0;
                    end
                end
            end else begin
                m_run[i] = 0;
            end
        end
        rst_ev  = fire[2] | hold_fire;
        e.pulse = {rst_ev, fire[1] & ~rst_ev, fire[0] & ~rst_ev};
        e.db    = m_db;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic rst, input logic [2:0] raw);
        reset         = rst;
        bus.btn_start = raw[0];
        bus.btn_pause = raw[1];
        bus.btn_reset = raw[2];
        @(posedge clk);
        cyc++;
        model_edge(rst, raw);
        #1;
    endtask

    task automatic run(input logic rst, input logic [2:0] raw, input int n);
        for (int k = 0; k < n; k++) cycle(rst, raw);
    endtask

    // Monitor: outputs are presented every cycle; compare each against the queue head.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.pulse = {bus.reset_pulse, bus.pause_pulse, bus.start_pulse};
            a.db    = {bus.reset_db, bus.pause_db, bus.start_db};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL outputs cycle %0d: got pulse=%b db=%b, expected pulse=%b db=%b",
                          cyc, a.pulse, a.db, e.pulse, e.db);
        end
    end

    initial begin
        logic [2:0] lvl;
        int         rem[3];
        reset         = 1'b1;
        bus.btn_start = 1'b0;
        bus.btn_pause = 1'b0;
        bus.btn_reset = 1'b0;
        raw_q         = {3'b000, 3'b000};
        m_db          = '0;
        m_run         = '{0, 0, 0};
        m_hold_n      = 0;
        m_hold_done   = 1'b0;

        run(1'b1, 3'b000, 2);
        // clean press and release
        run(1'b0, 3'b001, 30);
        run(1'b0, 3'b000, 12);
        // bounce on pause
        cycle(1'b0, 3'b010);
        cycle(1'b0, 3'b000);
        cycle(1'b0, 3'b010);
        cycle(1'b0, 3'b000);
        run(1'b0, 3'b000, 10);
        // start and reset together
        run(1'b0, 3'b101, 12);
        run(1'b0, 3'b000, 12);
        // reset during PRESS_WAIT
        run(1'b0, 3'b001, 5);
        run(1'b1, 3'b001, 1);
        run(1'b0, 3'b001, 12);
        run(1'b0, 3'b000, 12);
        // long pause hold
        run(1'b0, 3'b010, 40);
        run(1'b0, 3'b000, 12);
        // glitch while held
        run(1'b0, 3'b001, 12);
        run(1'b0, 3'b000, 2);
        run(1'b0, 3'b001, 10);
        run(1'b0, 3'b000, 12);

        // randomized levels with random dwell times, occasional reset
        lvl = '0;
        rem = '{0, 0, 0};
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    lvl[b] = $urandom_range(0, 1);
                    rem[b] = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 45)
                                                         : $urandom_range(1, 2 * DEB + 3);
                end
                rem[b]--;
            end
            cycle($urandom_range(0, 299) == 0, lvl);
        end
        run(1'b0, 3'b000, 12);

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
